// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the fetch/decode/execute sequencer.
// Optional feature macro: CTRL_SEQ_SINGLE_STEP_EN (adds the PAUSE state).
package ctrl_pkg;

  // Sequencer states; PAUSE exists only in single-step builds.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_OPND   = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALT   = 3'd5
`ifdef CTRL_SEQ_SINGLE_STEP_EN
    , ST_PAUSE = 3'd6
`endif
  } state_t;

  // Instruction classes held in IR[7:6].
  localparam logic [1:0] CLS_MOV = 2'b00;
  localparam logic [1:0] CLS_ALU = 2'b01;
  localparam logic [1:0] CLS_LDI = 2'b10;
  localparam logic [1:0] CLS_SYS = 2'b11;

  // Select codes for the register block's input mux.
  localparam logic [1:0] BUS_RF  = 2'd0;
  localparam logic [1:0] BUS_ALU = 2'd1;
  localparam logic [1:0] BUS_IMM = 2'd2;

  // Special encodings inside the system class.
  localparam logic [7:0] HLT_ENC    = 8'hFF;
  localparam logic [4:0] JMP_PREFIX = 5'b11001;

endpackage

// File: rtl/ctrl_sequencer_decoder.sv
// instr_decoder: purely combinational split of the instruction register
// into class, register fields and the control flags the sequencer needs.
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [7:0] ir,
  output logic [1:0] op_class,
  output logic [2:0] dst,
  output logic [2:0] src,
  output logic [2:0] func,
  output logic       needs_operand,
  output logic       is_halt,
  output logic       is_jmp
);

  // Field extraction; the destination field moves depending on class.
  always_comb begin
    op_class      = ir[7:6];
    dst           = 3'd0;
    src           = ir[2:0];
    func          = ir[5:3];
    needs_operand = 1'b0;
    is_halt       = 1'b0;
    is_jmp        = 1'b0;
    case (ir[7:6])
      CLS_MOV: dst = ir[5:3];
      CLS_ALU: dst = ir[2:0];
      CLS_LDI: begin
        dst           = ir[5:3];
        needs_operand = 1'b1;
      end
      CLS_SYS: begin
        is_jmp        = (ir[7:3] == JMP_PREFIX);
        needs_operand = (ir[7:3] == JMP_PREFIX);
        is_halt       = (ir == HLT_ENC);
      end
      default: dst = 3'd0;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle fetch/decode/execute control for the 8x8
// register block. All outputs are flops loaded from next-state values, so
// control lines are glitch-free and line up with the state they belong to.
// Optional feature macro: CTRL_SEQ_SINGLE_STEP_EN (step input, PAUSE after EXEC).
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter bit         AUTO_RUN = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic       instr_req,
  output logic [7:0] instr_addr,
  input  logic       instr_valid,
  input  logic [7:0] instr_data,
  output logic       rf_we,
  output logic       rf_oe,
  output logic [2:0] rf_iaddr,
  output logic [2:0] rf_oaddr,
  output logic [1:0] bus_sel,
  output logic [7:0] imm,
  output logic [2:0] alu_op,
  output logic       halted
`ifdef CTRL_SEQ_SINGLE_STEP_EN
  ,
  input  logic       step
`endif
);

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] imm_q, imm_d;

  logic       instr_req_q, instr_req_d;
  logic [7:0] instr_addr_q, instr_addr_d;
  logic       rf_we_q, rf_we_d;
  logic       rf_oe_q, rf_oe_d;
  logic [2:0] rf_iaddr_q, rf_iaddr_d;
  logic [2:0] rf_oaddr_q, rf_oaddr_d;
  logic [1:0] bus_sel_q, bus_sel_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic       halted_q, halted_d;

  logic [1:0] dec_class;
  logic [2:0] dec_dst, dec_src, dec_func;
  logic       dec_needs_operand, dec_is_halt, dec_is_jmp;

  instr_decoder u_decoder (
    .ir            (ir_q),
    .op_class      (dec_class),
    .dst           (dec_dst),
    .src           (dec_src),
    .func          (dec_func),
    .needs_operand (dec_needs_operand),
    .is_halt       (dec_is_halt),
    .is_jmp        (dec_is_jmp)
  );

  // Next-state, PC, IR and immediate update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    case (state_q)
      ST_IDLE: begin
        if (run || AUTO_RUN) state_d = ST_FETCH;
        else                 state_d = ST_IDLE;
      end
      ST_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr_data;
          pc_d    = pc_q + 8'd1;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (dec_is_halt)            state_d = ST_HALT;
        else if (dec_needs_operand) state_d = ST_OPND;
        else                        state_d = ST_EXEC;
      end
      ST_OPND: begin
        if (instr_valid) begin
          imm_d   = instr_data;
          pc_d    = pc_q + 8'd1;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_OPND;
        end
      end
      ST_EXEC: begin
        if (dec_is_jmp) pc_d = imm_q;
        else            pc_d = pc_q;
`ifdef CTRL_SEQ_SINGLE_STEP_EN
        state_d = ST_PAUSE;
`else
        state_d = ST_FETCH;
`endif
      end
      ST_HALT: begin
        if (run) state_d = ST_FETCH;
        else     state_d = ST_HALT;
      end
`ifdef CTRL_SEQ_SINGLE_STEP_EN
      ST_PAUSE: begin
        if (step) state_d = ST_FETCH;
        else      state_d = ST_PAUSE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the state being entered, so they register in step with it.
  always_comb begin
    instr_req_d  = (state_d == ST_FETCH) || (state_d == ST_OPND);
    instr_addr_d = 8'h00;
    halted_d     = (state_d == ST_HALT);
    rf_we_d      = 1'b0;
    rf_oe_d      = 1'b0;
    rf_iaddr_d   = 3'd0;
    rf_oaddr_d   = 3'd0;
    bus_sel_d    = BUS_RF;
    alu_op_d     = 3'd0;
    if (instr_req_d) instr_addr_d = pc_d;
    else             instr_addr_d = 8'h00;
    if (state_d == ST_EXEC) begin
      case (dec_class)
        CLS_MOV: begin
          rf_oe_d    = 1'b1;
          rf_oaddr_d = dec_src;
          rf_we_d    = 1'b1;
          rf_iaddr_d = dec_dst;
          bus_sel_d  = BUS_RF;
        end
        CLS_ALU: begin
          rf_we_d    = 1'b1;
          rf_iaddr_d = dec_dst;
          bus_sel_d  = BUS_ALU;
          alu_op_d   = dec_func;
        end
        CLS_LDI: begin
          rf_we_d    = 1'b1;
          rf_iaddr_d = dec_dst;
          bus_sel_d  = BUS_IMM;
        end
        default: rf_we_d = 1'b0;  // JMP and NOP never write
      endcase
    end else begin
      rf_we_d = 1'b0;
    end
  end

  // State and output registers; reset aborts any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      ir_q         <= 8'h00;
      imm_q        <= 8'h00;
      instr_req_q  <= 1'b0;
      instr_addr_q <= 8'h00;
      rf_we_q      <= 1'b0;
      rf_oe_q      <= 1'b0;
      rf_iaddr_q   <= 3'd0;
      rf_oaddr_q   <= 3'd0;
      bus_sel_q    <= 2'd0;
      alu_op_q     <= 3'd0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      imm_q        <= imm_d;
      instr_req_q  <= instr_req_d;
      instr_addr_q <= instr_addr_d;
      rf_we_q      <= rf_we_d;
      rf_oe_q      <= rf_oe_d;
      rf_iaddr_q   <= rf_iaddr_d;
      rf_oaddr_q   <= rf_oaddr_d;
      bus_sel_q    <= bus_sel_d;
      alu_op_q     <= alu_op_d;
      halted_q     <= halted_d;
    end
  end

  assign instr_req  = instr_req_q;
  assign instr_addr = instr_addr_q;
  assign rf_we      = rf_we_q;
  assign rf_oe      = rf_oe_q;
  assign rf_iaddr   = rf_iaddr_q;
  assign rf_oaddr   = rf_oaddr_q;
  assign bus_sel    = bus_sel_q;
  assign imm        = imm_q;
  assign alu_op     = alu_op_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: instruction-level reference model with a program memory
// and randomized wait states / ignored-input noise.
// Optional feature macro: CTRL_SEQ_SINGLE_STEP_EN (bench drives step).
module tb_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, run, instr_valid;
  logic [7:0] instr_data;
  logic       instr_req, rf_we, rf_oe, halted;
  logic [7:0] instr_addr, imm;
  logic [2:0] rf_iaddr, rf_oaddr, alu_op;
  logic [1:0] bus_sel;
`ifdef CTRL_SEQ_SINGLE_STEP_EN
  logic       step;
`endif

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] mem [0:255];
  logic [7:0] model_pc;

  ctrl_sequencer #(.RESET_PC(8'h00), .AUTO_RUN(1'b0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .instr_req   (instr_req),
    .instr_addr  (instr_addr),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .rf_we       (rf_we),
    .rf_oe       (rf_oe),
    .rf_iaddr    (rf_iaddr),
    .rf_oaddr    (rf_oaddr),
    .bus_sel     (bus_sel),
    .imm         (imm),
    .alu_op      (alu_op),
    .halted      (halted)
`ifdef CTRL_SEQ_SINGLE_STEP_EN
    ,
    .step        (step)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [12:0] ctl_vec();
    return {rf_we, rf_oe, rf_iaddr, rf_oaddr, bus_sel, alu_op};
  endfunction

  // Inputs the sequencer must ignore in non-request states.
  task automatic noise(input bit allow_run);
    instr_valid = 1'($urandom_range(0, 1));
    instr_data  = 8'($urandom);
    run         = allow_run ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  // One byte over the handshake at model_pc, with waits (<0 means random).
  task automatic fetch_byte(input string tag, input int waits, output logic [7:0] b);
    int w;
    w = (waits < 0) ? int'($urandom_range(0, 2)) : waits;
    check({tag, "_req"}, 32'(instr_req), 32'd1);
    check({tag, "_addr"}, 32'(instr_addr), 32'(model_pc));
    for (int i = 0; i < w; i++) begin
      instr_valid = 1'b0;
      instr_data  = 8'($urandom);
      run         = 1'($urandom_range(0, 1));
      tick();
      check({tag, "_wait_req"}, 32'(instr_req), 32'd1);
      check({tag, "_wait_addr"}, 32'(instr_addr), 32'(model_pc));
    end
    instr_valid = 1'b1;
    instr_data  = mem[model_pc];
    run         = 1'($urandom_range(0, 1));
    b           = mem[model_pc];
    tick();
    model_pc = model_pc + 8'd1;
  endtask

  // Execute one instruction starting at the negedge of its FETCH cycle.
  task automatic exec_one(input int waits);
    logic [7:0]  op, opnd;
    logic [12:0] exp_ctl;
    bit          has_opnd;
    check("fetch_halted", 32'(halted), 32'd0);
    fetch_byte("fetch", waits, op);
    check("decode_req", 32'(instr_req), 32'd0);
    check("decode_ctl", 32'(ctl_vec()), 32'd0);
    has_opnd = (op[7:6] == 2'b10) || (op[7:3] == 5'b11001);
    noise(1'b1);
    tick();
    opnd = 8'h00;
    if (has_opnd) fetch_byte("opnd", waits, opnd);
    if (op == 8'hFF) begin
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_req", 32'(instr_req), 32'd0);
      check("halt_ctl", 32'(ctl_vec()), 32'd0);
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
        noise(1'b0);
        tick();
        check("halt_hold", 32'({halted, instr_req}), 32'b10);
      end
      instr_valid = 1'b0;
      run         = 1'b1;
      tick();
      run = 1'b0;
      return;
    end
    // Expected EXEC controls: {we, oe, iaddr, oaddr, bus_sel, alu_op}
    case (op[7:6])
      2'b00:   exp_ctl = {1'b1, 1'b1, op[5:3], op[2:0], 2'd0, 3'd0};
      2'b01:   exp_ctl = {1'b1, 1'b0, op[2:0], 3'd0, 2'd1, op[5:3]};
      2'b10:   exp_ctl = {1'b1, 1'b0, op[5:3], 3'd0, 2'd2, 3'd0};
      default: exp_ctl = 13'd0;
    endcase
    check("exec_ctl", 32'(ctl_vec()), 32'(exp_ctl));
    check("exec_req_halted", 32'({instr_req, halted}), 32'd0);
    if (has_opnd) check("exec_imm", 32'(imm), 32'(opnd));
    if (op[7:3] == 5'b11001) model_pc = opnd;
    noise(1'b1);
    tick();
`ifdef CTRL_SEQ_SINGLE_STEP_EN
    for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
      check("pause_quiet", 32'({instr_req, halted, ctl_vec()}), 32'd0);
      noise(1'b1);
      step = 1'b0;
      tick();
    end
    instr_valid = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
`endif
  endtask

  initial begin
    rst_n       = 1'b0;
    run         = 1'b0;
    instr_valid = 1'b0;
    instr_data  = 8'h00;
`ifdef CTRL_SEQ_SINGLE_STEP_EN
    step        = 1'b0;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 8'hC0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({instr_req, instr_addr, ctl_vec(), imm, halted}), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_no_run", 32'(instr_req), 32'd0);

    // Reset in the middle of a stalled fetch.
    run = 1'b1;
    tick();
    run = 1'b0;
    check("first_fetch", 32'({instr_req, instr_addr}), 32'h100);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1 check("async_abort", 32'({instr_req, instr_addr, rf_we}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("after_abort_idle", 32'(instr_req), 32'd0);

    // Directed program: MOV, LDI, ALU, JMP to FE, JMP across wrap, NOP at FF, HLT.
    mem[8'h00] = 8'h0A; mem[8'h01] = 8'h98; mem[8'h02] = 8'h5A;
    mem[8'h03] = 8'h6D; mem[8'h04] = 8'hC8; mem[8'h05] = 8'hFE;
    mem[8'hFE] = 8'hC8; mem[8'hFF] = 8'h10;
    mem[8'h10] = 8'hC8; mem[8'h11] = 8'hFF;
    model_pc = 8'h00;
    run = 1'b1;
    tick();
    run = 1'b0;
    exec_one(0);      // MOV r1 <- r2
    exec_one(2);      // LDI r3 <- 5A with two wait states per byte
    exec_one(0);      // ALU f=5 into r5
    exec_one(-1);     // JMP FE
    exec_one(-1);     // JMP at FE, operand from FF -> 10
    mem[8'hFF] = 8'hC0;
    mem[8'h00] = 8'hFF;
    exec_one(-1);     // JMP FF
    exec_one(-1);     // NOP at FF, PC wraps to 00
    exec_one(-1);     // HLT at 00, resume at 01

    // Random program from wherever the model is.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 200; i++) exec_one(-1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
